// File: rtl/dcache_pkg.sv
// Shared types and address-field helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  localparam int LINES     = 16;
  localparam int LINE_BITS = 256;
  localparam int OFFSET_W  = 5;
  localparam int INDEX_W   = 4;
  localparam int TAG_W     = 23;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_e;

  // Extract a right-aligned field of 'width' bits starting at bit 'lsb'.
  function automatic logic [31:0] addr_field(input logic [31:0] addr, input int lsb, input int width);
    logic [31:0] mask_s;
    mask_s = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (addr >> lsb) & mask_s;
  endfunction

endpackage

// File: rtl/dcache_sram.sv
// Tag/valid/dirty/data storage: combinational read port, clocked write port, async valid/dirty clear.
module dcache_sram
  import dcache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256,
  parameter int IDX_BITS  = INDEX_W,
  parameter int TAG_BITS  = TAG_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IDX_BITS-1:0]  rd_index,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_data,
  input  logic                 wr_dirty
);

  logic [LINES-1:0]     valid_r;
  logic [LINES-1:0]     dirty_r;
  logic [TAG_BITS-1:0]  tag_r  [LINES];
  logic [LINE_BITS-1:0] data_r [LINES];

  assign rd_valid = valid_r[rd_index];
  assign rd_dirty = dirty_r[rd_index];
  assign rd_tag   = tag_r[rd_index];
  assign rd_data  = data_r[rd_index];

  // Line state bits; cleared on reset so every line is invalid afterwards.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_r <= {LINES{1'b0}};
      dirty_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_index] <= 1'b1;
      dirty_r[wr_index] <= wr_dirty;
    end
  end

  // Tag and data payload, not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      tag_r[wr_index]  <= wr_tag;
      data_r[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache controller with global pipeline stall.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_controller
  import dcache_pkg::*;
#(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]          hit_count_o,
  output logic [31:0]          miss_count_o
`endif
);

  localparam int OFF_W    = $clog2(LINE_BITS / 8);
  localparam int IDX_W    = $clog2(LINES);
  localparam int TAG_BITS = 32 - OFF_W - IDX_W;
  localparam int WSEL_W   = OFF_W - 2;

  state_e               state_r;
  logic                 mem_req_r;
  logic                 mem_write_r;
  logic [31:0]          mem_addr_r;
  logic [LINE_BITS-1:0] mem_data_r;

  logic [IDX_W-1:0]     index_s;
  logic [TAG_BITS-1:0]  tag_s;
  logic [WSEL_W-1:0]    word_s;
  logic                 rd_valid_s;
  logic                 rd_dirty_s;
  logic [TAG_BITS-1:0]  rd_tag_s;
  logic [LINE_BITS-1:0] rd_data_s;
  logic                 wr_en_s;
  logic [TAG_BITS-1:0]  wr_tag_s;
  logic [LINE_BITS-1:0] wr_data_s;
  logic                 wr_dirty_s;
  logic [31:0]          rd_word_s;
  logic [LINE_BITS-1:0] merged_s;
  logic                 hit_s;
  logic                 idle_s;

  assign index_s = IDX_W'(addr_field(cpu_addr_i, OFF_W, IDX_W));
  assign tag_s   = TAG_BITS'(addr_field(cpu_addr_i, OFF_W + IDX_W, TAG_BITS));
  assign word_s  = WSEL_W'(addr_field(cpu_addr_i, 2, WSEL_W));

  dcache_sram #(
    .LINES     (LINES),
    .LINE_BITS (LINE_BITS),
    .IDX_BITS  (IDX_W),
    .TAG_BITS  (TAG_BITS)
  ) u_sram (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_index (index_s),
    .rd_valid (rd_valid_s),
    .rd_dirty (rd_dirty_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_index (index_s),
    .wr_tag   (wr_tag_s),
    .wr_data  (wr_data_s),
    .wr_dirty (wr_dirty_s)
  );

  assign idle_s = (state_r == ST_IDLE);
  assign hit_s  = cpu_req_i & rd_valid_s & (rd_tag_s == tag_s);

  // Word select for loads and word merge for stores.
  always_comb begin
    rd_word_s = rd_data_s[{word_s, 5'd0} +: 32];
    merged_s  = rd_data_s;
    merged_s[{word_s, 5'd0} +: 32] = cpu_data_i;
  end

  // Array write port: store hit merges and marks dirty, refill installs a clean line.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_tag_s   = tag_s;
    wr_data_s  = merged_s;
    wr_dirty_s = 1'b0;
    if (idle_s && hit_s && cpu_write_i) begin
      wr_en_s    = 1'b1;
      wr_dirty_s = 1'b1;
    end else if ((state_r == ST_ALLOCATE) && mem_ack_i) begin
      wr_en_s    = 1'b1;
      wr_data_s  = mem_data_i;
      wr_dirty_s = 1'b0;
    end else begin
      wr_en_s    = 1'b0;
    end
  end

  // Miss-service FSM; memory-side outputs are registered and held until acked.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      mem_req_r   <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= 32'd0;
      mem_data_r  <= {LINE_BITS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (cpu_req_i && !hit_s) begin
            mem_req_r <= 1'b1;
            if (rd_valid_s && rd_dirty_s) begin
              state_r     <= ST_WRITEBACK;
              mem_write_r <= 1'b1;
              mem_addr_r  <= {rd_tag_s, index_s, {OFF_W{1'b0}}};
              mem_data_r  <= rd_data_s;
            end else begin
              state_r     <= ST_ALLOCATE;
              mem_write_r <= 1'b0;
              mem_addr_r  <= {tag_s, index_s, {OFF_W{1'b0}}};
              mem_data_r  <= {LINE_BITS{1'b0}};
            end
          end
        end
        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            state_r     <= ST_ALLOCATE;
            mem_write_r <= 1'b0;
            mem_addr_r  <= {tag_s, index_s, {OFF_W{1'b0}}};
            mem_data_r  <= {LINE_BITS{1'b0}};
          end
        end
        ST_ALLOCATE: begin
          if (mem_ack_i) begin
            state_r     <= ST_IDLE;
            mem_req_r   <= 1'b0;
            mem_write_r <= 1'b0;
            mem_addr_r  <= 32'd0;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          mem_req_r   <= 1'b0;
          mem_write_r <= 1'b0;
          mem_addr_r  <= 32'd0;
          mem_data_r  <= {LINE_BITS{1'b0}};
        end
      endcase
    end
  end

  assign mem_req_o   = mem_req_r;
  assign mem_write_o = mem_write_r;
  assign mem_addr_o  = mem_addr_r;
  assign mem_data_o  = mem_data_r;

  // Stall is held low while reset is asserted so the pipeline restarts cleanly.
  assign cpu_stall_o = ~rst_i & (~idle_s | (cpu_req_i & ~hit_s));
  assign cpu_data_o  = (idle_s & hit_s & ~cpu_write_i) ? rd_word_s : 32'd0;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_r;
  logic [31:0] miss_count_r;
  logic        retry_r;

  // A hit completing a refilled request is a retry, not a first-presentation hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_count_r  <= 32'd0;
      miss_count_r <= 32'd0;
      retry_r      <= 1'b0;
    end else if (idle_s && hit_s) begin
      retry_r <= 1'b0;
      if (!retry_r) begin
        hit_count_r <= hit_count_r + 32'd1;
      end
    end else if (idle_s && cpu_req_i) begin
      retry_r      <= 1'b1;
      miss_count_r <= miss_count_r + 32'd1;
    end
  end

  assign hit_count_o  = hit_count_r;
  assign miss_count_o = miss_count_r;
`endif

endmodule

// File: doc/dcache_controller.md
# dcache_controller

Direct-mapped, write-back, write-allocate data cache controller between the MEM stage and off-chip data memory. It generates the global pipeline stall that freezes IF_ID/ID_EX/EX_MEM/MEM_WB while a miss is serviced. It is the responder to the pipeline's MemRead/MemWrite requests and the initiator toward data memory.

## Interface
- Parameters:
- LINES, 16, number of cache lines (power of two)
- LINE_BITS, 256, line width (32 bytes, 8 words)
- Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- cpu_req_i  in  1  MEM-stage access valid (MemRead | MemWrite)
- cpu_write_i  in  1  1 = store, 0 = load
- cpu_addr_i  in  32  byte address, word-aligned
- cpu_data_i  in  32  store data
- cpu_data_o  out  32  load data, valid when cpu_req_i & ~cpu_stall_o
- cpu_stall_o  out  1  pipeline stall, drives every pipeline register Stall_i
- mem_req_o  out  1  memory request
- mem_write_o  out  1  1 = line write-back, 0 = line fetch
- mem_addr_o  out  32  line address, bits [4:0] = 0
- mem_data_o  out  256  write-back line
- mem_data_i  in  256  fetched line, valid with mem_ack_i
- mem_ack_i  in  1  one-cycle completion pulse

## Operation
- Address split: offset [4:0], word select [4:2], index [8:5], tag [31:9] (23 b) for LINES=16.
- Per line: valid, dirty, tag, 256-b data. Valid and dirty are reset asynchronously to 0; tag and data are not reset.
- hit = cpu_req_i & valid[index] & (tag[index] == cpu_addr_i[31:9]).
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Load hit: cpu_data_o = selected word, same cycle.
  - Store hit: merge cpu_data_i into the selected word at the clock edge; set dirty.
  - Miss with dirty victim -> WRITEBACK.
  - Miss with clean or invalid victim -> ALLOCATE.
- WRITEBACK: mem_req_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line. On mem_ack_i -> ALLOCATE.
- ALLOCATE: mem_req_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 5'b0}. On mem_ack_i, write mem_data_i into the line with valid=1, dirty=0, tag updated, then -> IDLE.
- Back in IDLE the frozen request re-evaluates as a hit and completes: the store merges, or the load returns data.
- cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit).
- cpu_data_o = 0 whenever there is no load hit.

## Timing
- Reset values: state IDLE, cpu_stall_o 0, cpu_data_o 0, mem_req_o 0, mem_write_o 0, mem_addr_o 0, mem_data_o 0.
- Hit latency: 0 extra cycles; stall never asserts.
- Miss stall: asserted combinationally in the request cycle.
  - Clean miss: stall lasts 1 + (cycles until ALLOCATE ack) cycles; deasserts the cycle after the ack.
  - Dirty miss: adds the WRITEBACK wait before ALLOCATE.
- Memory handshake:
  - mem_req_o, mem_write_o, mem_addr_o and mem_data_o are registered and held stable until the cycle mem_ack_i is sampled high.
  - mem_req_o drops in the cycle after the ack.
  - mem_ack_i is ignored in IDLE.
  - An ack in the same cycle the request rises is legal.
- cpu_req_i and cpu_addr_i are held stable by the stalled pipeline. The controller does not latch them.
- Reset mid-miss: immediate return to IDLE, mem_req_o drops, all lines are invalidated. Data held by memory keeps its partial state.
- Back-to-back accesses to the same missing line: the second access hits after the refill.
- Index conflict (A then B with the same index): B evicts A; A is written back first if dirty.

## Configuration
- DCACHE_STATS_EN defined:
  - Adds ports hit_count_o [31:0] and miss_count_o [31:0].
  - hit_count_o increments once per completed access that hit on first presentation.
  - miss_count_o increments once per IDLE->WRITEBACK/ALLOCATE transition.
  - Both wrap modulo 2^32 and reset to 0.
- DCACHE_STATS_EN undefined: no counters, no extra ports, identical cache behaviour.

## Structure
- dcache_pkg: state enum, TAG_W, INDEX_W, OFFSET_W, LINE_BITS, and address-field extraction functions.
- Sub-module dcache_sram: tag/valid/dirty/data arrays with one read port (combinational) and one write port (clocked), plus asynchronous valid/dirty clear.
- dcache_controller: FSM, hit logic, word merge/select and memory-side registers.

## Test plan
- Cold load 0x0000_0104, memory line holds word 1 = 0xDEAD_BEEF, ack after 5 cycles -> stall high 6 cycles; then cpu_data_o=0xDEAD_BEEF with stall low.
- Store 0x1234_5678 to 0x104 after the refill -> no stall; following load of 0x104 returns 0x1234_5678; line is dirty.
- Load 0x0000_0304 (same index 8, different tag) -> WRITEBACK with mem_addr_o=0x100 and the dirty line on mem_data_o, then ALLOCATE with mem_addr_o=0x300.
- Ack in the same cycle as mem_req_o rises -> state advances in one cycle; no duplicate request is issued.
- Assert rst_i during ALLOCATE -> mem_req_o=0 and cpu_stall_o=0 immediately; next load of 0x104 misses again.
- DCACHE_STATS_EN build running the sequence above -> hit_count_o=2, miss_count_o=2.
